dram_model_param: RTL and testbench



---
 rtl/dram_model_param_pkg.sv | 40 ++++
 rtl/dram_model_param_if.sv | 27 ++
 rtl/dram_rd_pipe.sv | 36 +++
 rtl/dram_model_param.sv | 149 ++++++++++++++
 tb/tb_dram_model_param.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_model_param_pkg.sv
// Shared types and helpers for the parametrised DRAM model.
// Request/state encodings plus the block index and next-address rules.
package dram_model_param_pkg;

  localparam int unsigned ADRW = 32;

  localparam logic [1:0] DRAM_REQ_IDLE  = 2'b00;
  localparam logic [1:0] DRAM_REQ_READ  = 2'b01;
  localparam logic [1:0] DRAM_REQ_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10
  } dram_state_e;

  // Burst request as presented by the sort core.
  typedef struct packed {
    logic [1:0]      req;
    logic [ADRW-1:0] initadr;
    logic [ADRW-1:0] elem;
  } dram_burst_t;

  // Array index of a byte address: (addr / step) mod depth.
  function automatic logic [ADRW-1:0] dram_index(input logic [ADRW-1:0] addr,
                                                 input int unsigned step,
                                                 input int unsigned depth);
    return (addr / ADRW'(step)) % ADRW'(depth);
  endfunction

  // Next block address; wraps to 0 after the last block of the array.
  function automatic logic [ADRW-1:0] dram_next_addr(input logic [ADRW-1:0] addr,
                                                     input int unsigned step,
                                                     input int unsigned depth);
    logic [ADRW-1:0] last;
    last = ADRW'((depth - 1) * step);
    return (addr == last) ? '0 : addr + ADRW'(step);
  endfunction

endpackage

// File: rtl/dram_model_param_if.sv
// Sort-core side request/data interface of the DRAM model.
interface dram_model_param_if #(
  parameter int unsigned DATAW = 512
);
  import dram_model_param_pkg::*;

  logic [1:0]       D_REQ;
  logic [ADRW-1:0]  D_INITADR;
  logic [ADRW-1:0]  D_ELEM;
  logic [DATAW-1:0] D_DIN;
  logic             D_W;
  logic [DATAW-1:0] D_DOUT;
  logic             D_DOUTEN;
  logic             D_BUSY;

  // Core side: issues bursts and supplies write data.
  modport master (
    output D_REQ, D_INITADR, D_ELEM, D_DIN,
    input  D_W, D_DOUT, D_DOUTEN, D_BUSY
  );

  // Memory side.
  modport slave (
    input  D_REQ, D_INITADR, D_ELEM, D_DIN,
    output D_W, D_DOUT, D_DOUTEN, D_BUSY
  );
endinterface

// File: rtl/dram_rd_pipe.sv
// Valid + index shift pipeline for in-flight reads; clear drops all entries.
module dram_rd_pipe #(
  parameter int unsigned STAGES = 1,
  parameter int unsigned IDXW   = 10
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            in_vld,
  input  logic [IDXW-1:0] in_idx,
  output logic            out_vld,
  output logic [IDXW-1:0] out_idx
);

  logic            vld_q [STAGES];
  logic [IDXW-1:0] idx_q [STAGES];

  // Valid bits shift forward and are cleared on reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < int'(STAGES); i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= in_vld;
      for (int i = 1; i < int'(STAGES); i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Indices travel alongside their valid bits.
  always_ff @(posedge clk) begin
    idx_q[0] <= in_idx;
    for (int i = 1; i < int'(STAGES); i++) idx_q[i] <= idx_q[i-1];
  end

  assign out_vld = vld_q[STAGES-1];
  assign out_idx = idx_q[STAGES-1];

endmodule

// File: rtl/dram_model_param.sv
// Parametrised behavioural DRAM model serving block read/write bursts.
// Optional ready-stall injection: define DRAM_MODEL_STALL_EN.
module dram_model_param
  import dram_model_param_pkg::*;
#(
  parameter int unsigned DATAW        = 512,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned ADR_STEP     = 8,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STALL_PERIOD = 4
) (
  input  logic               CLK,
  input  logic               RST,
  dram_model_param_if.slave  bus
);

  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SCW  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

`ifdef DRAM_MODEL_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  dram_state_e      state, state_nxt;
  logic             start, w_fire, rd_issue, rdy;
  logic [ADRW-1:0]  addr, remain, issue_rem, ret_rem;
  logic [IDXW-1:0]  cur_idx, wa_idx, leave_idx;
  logic             wr_pend, leave_vld;
  logic [DATAW-1:0] dout;
  logic             douten;
  logic [SCW-1:0]   scnt;
  logic [DATAW-1:0] mem [DEPTH];

  // Free-running stall phase counter; only steers rdy when stalls are built in.
  always_ff @(posedge CLK) begin
    if (RST) scnt <= '0;
    else if (scnt == SCW'(STALL_PERIOD - 1)) scnt <= '0;
    else scnt <= scnt + SCW'(1);
  end

  assign rdy = !STALL_ON || (scnt != SCW'(STALL_PERIOD - 1));

  assign cur_idx = IDXW'(dram_index(addr, ADR_STEP, DEPTH));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, burst start, write strobe and read issue.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    w_fire    = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.D_ELEM != '0) begin
          if (bus.D_REQ == DRAM_REQ_WRITE) begin
            state_nxt = ST_WRITE;
            start     = 1'b1;
          end else if (bus.D_REQ == DRAM_REQ_READ) begin
            state_nxt = ST_READ;
            start     = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (rdy) begin
          w_fire = 1'b1;
          if (remain == ADRW'(1)) state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if ((issue_rem != '0) && rdy) rd_issue = 1'b1;
        if (ret_rem == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read issue pipeline; with RD_LAT of 1 the entry leaves in its issue cycle.
  if (RD_LAT > 1) begin : g_pipe
    dram_rd_pipe #(
      .STAGES (RD_LAT - 1),
      .IDXW   (IDXW)
    ) u_rd_pipe (
      .clk     (CLK),
      .clear   (RST),
      .in_vld  (rd_issue),
      .in_idx  (cur_idx),
      .out_vld (leave_vld),
      .out_idx (leave_idx)
    );
  end else begin : g_nopipe
    assign leave_vld = rd_issue;
    assign leave_idx = cur_idx;
  end

  // Burst bookkeeping, write-address capture and registered read return.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr      <= '0;
      remain    <= '0;
      issue_rem <= '0;
      ret_rem   <= '0;
      wr_pend   <= 1'b0;
      wa_idx    <= '0;
      dout      <= '0;
      douten    <= 1'b0;
    end else begin
      wr_pend <= w_fire;
      if (start) begin
        addr      <= bus.D_INITADR;
        remain    <= bus.D_ELEM;
        issue_rem <= bus.D_ELEM;
        ret_rem   <= bus.D_ELEM;
      end else if (w_fire) begin
        wa_idx <= cur_idx;
        addr   <= dram_next_addr(addr, ADR_STEP, DEPTH);
        remain <= remain - ADRW'(1);
      end else if (rd_issue) begin
        addr      <= dram_next_addr(addr, ADR_STEP, DEPTH);
        issue_rem <= issue_rem - ADRW'(1);
      end
      if (leave_vld) begin
        dout    <= mem[leave_idx];
        douten  <= 1'b1;
        ret_rem <= ret_rem - ADRW'(1);
      end else begin
        douten  <= 1'b0;
      end
    end
  end

  // Store lands the cycle after its strobe; contents survive reset.
  always_ff @(posedge CLK) begin
    if (!RST && wr_pend) mem[wa_idx] <= bus.D_DIN;
  end

  assign bus.D_W      = w_fire;
  assign bus.D_BUSY   = (state != ST_IDLE);
  assign bus.D_DOUT   = dout;
  assign bus.D_DOUTEN = douten;

endmodule

// File: tb/tb_dram_model_param.sv
// Self-checking bench for dram_model_param: two instances (RD_LAT 1 and 5),
// table-driven bursts, randomized bursts and a mid-read reset sequence.
module tb_dram_model_param;
  import dram_model_param_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned DEP  = 16;
  localparam int unsigned STEP = 8;
  localparam int unsigned SP   = 3;

`ifdef DRAM_MODEL_STALL_EN
  localparam bit STALL_TB = 1'b1;
`else
  localparam bit STALL_TB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [31:0] adr = '0;
  logic [31:0] elem = '0;
  logic [31:0] din = '0;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  dram_model_param_if #(.DATAW(DW)) bus1 ();
  dram_model_param_if #(.DATAW(DW)) bus5 ();

  assign bus1.D_REQ     = sel ? DRAM_REQ_IDLE : req;
  assign bus5.D_REQ     = sel ? req : DRAM_REQ_IDLE;
  assign bus1.D_INITADR = adr;
  assign bus5.D_INITADR = adr;
  assign bus1.D_ELEM    = elem;
  assign bus5.D_ELEM    = elem;
  assign bus1.D_DIN     = din;
  assign bus5.D_DIN     = din;

  dram_model_param #(.DATAW(DW), .DEPTH(DEP), .ADR_STEP(STEP), .RD_LAT(1), .STALL_PERIOD(SP))
    dut1 (.CLK(clk), .RST(rst), .bus(bus1));
  dram_model_param #(.DATAW(DW), .DEPTH(DEP), .ADR_STEP(STEP), .RD_LAT(5), .STALL_PERIOD(SP))
    dut5 (.CLK(clk), .RST(rst), .bus(bus5));

  logic        o_w, o_busy, o_douten;
  logic [31:0] o_dout;
  assign o_w      = sel ? bus5.D_W      : bus1.D_W;
  assign o_busy   = sel ? bus5.D_BUSY   : bus1.D_BUSY;
  assign o_douten = sel ? bus5.D_DOUTEN : bus1.D_DOUTEN;
  assign o_dout   = sel ? bus5.D_DOUT   : bus1.D_DOUT;

  int          checks = 0;
  int          errors = 0;
  int unsigned phase = 0;
  logic [31:0] ref_mem [2][DEP];

  typedef struct {
    logic [1:0]  rq;
    logic [31:0] a;
    logic [31:0] n;
    logic [31:0] base;
    bit          exp_start;
    bit          noise;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / STEP) % DEP);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a);
    return (a == 32'((DEP - 1) * STEP)) ? 32'd0 : a + 32'(STEP);
  endfunction

  function automatic bit rdy_now();
    return !STALL_TB || (phase != SP - 1);
  endfunction

  // Advance one clock; track the stall phase (cycles since reset, mod SP).
  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    phase = r ? 0 : (phase + 1) % SP;
  endtask

  // Issue one request to the selected DUT and check the whole burst against the model.
  task automatic run_req(input logic [1:0] rq, input logic [31:0] a0, input logic [31:0] n,
                         input logic [31:0] base, input bit exp_start, input bit noise);
    int          s, lat, k, issued, returned;
    logic [31:0] a, pdata;
    bit          have_pend, done;
    int          rt[$];
    logic [31:0] rd[$];
    s   = sel ? 1 : 0;
    lat = sel ? 5 : 1;
    a   = a0;
    req = rq; adr = a0; elem = n;
    tick();
    req = DRAM_REQ_IDLE; elem = '0;
    chk("busy_start", 32'(o_busy), 32'(exp_start));
    if (!exp_start) begin
      repeat (3) begin
        chk("idle_busy", 32'(o_busy), 0);
        chk("idle_strobe", 32'(o_w), 0);
        chk("idle_valid", 32'(o_douten), 0);
        tick();
      end
    end else if (rq == DRAM_REQ_WRITE) begin
      k = 0; have_pend = 1'b0; done = 1'b0; pdata = '0;
      for (int j = 0; j < int'(4 * n + 10) && !done; j++) begin
        if (have_pend) begin din = pdata; have_pend = 1'b0; end
        chk("write_busy", 32'(o_busy), 32'(k < int'(n)));
        chk("write_strobe", 32'(o_w), 32'((k < int'(n)) && rdy_now()));
        chk("write_valid", 32'(o_douten), 0);
        if ((k < int'(n)) && rdy_now()) begin
          pdata = base + 32'(k);
          ref_mem[s][m_idx(a)] = pdata;
          a = m_next(a);
          k++;
          have_pend = 1'b1;
        end
        if (k == int'(n) && !have_pend) done = 1'b1;
        else tick();
      end
      if (!done) chk("write_timeout", 0, 1);
    end else begin
      issued = 0; returned = 0;
      for (int j = 1; j < int'(4 * n) + lat + 10 && returned < int'(n); j++) begin
        if (noise && j == 2) begin req = DRAM_REQ_WRITE; adr = a0; elem = 4; end
        else begin req = DRAM_REQ_IDLE; elem = '0; end
        if (issued < int'(n) && rdy_now()) begin
          rt.push_back(j + lat);
          rd.push_back(ref_mem[s][m_idx(a)]);
          a = m_next(a);
          issued++;
        end
        chk("read_busy", 32'(o_busy), 1);
        chk("read_no_strobe", 32'(o_w), 0);
        if (rt.size() > 0 && rt[0] == j) begin
          chk("read_valid", 32'(o_douten), 1);
          chk("read_data", o_dout, rd[0]);
          void'(rt.pop_front());
          void'(rd.pop_front());
          returned++;
        end else begin
          chk("read_valid", 32'(o_douten), 0);
        end
        if (returned < int'(n)) tick();
      end
      if (returned < int'(n)) chk("read_timeout", 32'(returned), n);
      req = DRAM_REQ_IDLE; elem = '0;
      tick();
      chk("read_end_busy", 32'(o_busy), 0);
      chk("read_end_valid", 32'(o_douten), 0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rq;
    logic [31:0] ra, rn;
    int          seen;
    repeat (3) tick();
    // Reset values on both instances.
    chk("rst_busy1", 32'(bus1.D_BUSY), 0);
    chk("rst_w1", 32'(bus1.D_W), 0);
    chk("rst_valid1", 32'(bus1.D_DOUTEN), 0);
    chk("rst_dout1", bus1.D_DOUT, 0);
    chk("rst_busy5", 32'(bus5.D_BUSY), 0);
    chk("rst_dout5", bus5.D_DOUT, 0);
    rst = 1'b0;

    tbl[0]  = '{DRAM_REQ_WRITE, 32'h000, 32'd16, 32'h1000, 1'b1, 1'b0};
    tbl[1]  = '{DRAM_REQ_IDLE,  32'h100, 32'd4,  32'h0,    1'b0, 1'b0};
    tbl[2]  = '{2'b11,          32'h100, 32'd4,  32'h0,    1'b0, 1'b0};
    tbl[3]  = '{DRAM_REQ_READ,  32'h100, 32'd0,  32'h0,    1'b0, 1'b0};
    tbl[4]  = '{DRAM_REQ_WRITE, 32'h100, 32'd0,  32'h0,    1'b0, 1'b0};
    tbl[5]  = '{DRAM_REQ_WRITE, 32'h100, 32'd4,  32'hA0,   1'b1, 1'b0};
    tbl[6]  = '{DRAM_REQ_READ,  32'h100, 32'd4,  32'h0,    1'b1, 1'b0};
    tbl[7]  = '{DRAM_REQ_WRITE, 32'h070, 32'd3,  32'hC0,   1'b1, 1'b0};
    tbl[8]  = '{DRAM_REQ_READ,  32'h070, 32'd3,  32'h0,    1'b1, 1'b0};
    tbl[9]  = '{DRAM_REQ_READ,  32'h000, 32'd1,  32'h0,    1'b1, 1'b0};
    tbl[10] = '{DRAM_REQ_READ,  32'h100, 32'd4,  32'h0,    1'b1, 1'b1};
    tbl[11] = '{DRAM_REQ_WRITE, 32'h028, 32'd6,  32'hD0,   1'b1, 1'b0};
    tbl[12] = '{DRAM_REQ_READ,  32'h028, 32'd6,  32'h0,    1'b1, 1'b0};

    for (int i = 0; i < 13; i++)
      run_req(tbl[i].rq, tbl[i].a, tbl[i].n, tbl[i].base, tbl[i].exp_start, tbl[i].noise);

    // Explicit wrap placement: index 0 must now hold the third block of the 0x70 burst.
    run_req(DRAM_REQ_READ, 32'h000, 32'd1, 32'h0, 1'b1, 1'b0);
    chk("wrap_model_idx0", ref_mem[0][0], 32'hC2);

    // Reset in the middle of an 8-block read after three returns.
    run_req(DRAM_REQ_WRITE, 32'h180, 32'd8, 32'h5500, 1'b1, 1'b0);
    req = DRAM_REQ_READ; adr = 32'h180; elem = 32'd8;
    tick();
    req = DRAM_REQ_IDLE; elem = '0;
    seen = 0;
    for (int j = 0; j < 60 && seen < 3; j++) begin
      if (o_douten) begin
        chk("rst_read_data", o_dout, 32'h5500 + 32'(seen));
        seen++;
      end
      if (seen < 3) tick();
    end
    chk("rst_read_seen", 32'(seen), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(o_busy), 0);
    chk("rst_mid_valid", 32'(o_douten), 0);
    repeat (4) begin
      tick();
      chk("rst_after_busy", 32'(o_busy), 0);
      chk("rst_after_valid", 32'(o_douten), 0);
    end
    run_req(DRAM_REQ_READ, 32'h180, 32'd8, 32'h0, 1'b1, 1'b0);

    // Randomized bursts on the RD_LAT=1 instance.
    for (int i = 0; i < 30; i++) begin
      rq = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 511));
      rn = 32'($urandom_range(0, 6));
      run_req(rq, ra, rn, $urandom,
              ((rq == DRAM_REQ_READ) || (rq == DRAM_REQ_WRITE)) && (rn != 0),
              (rq == DRAM_REQ_READ) && (rn >= 3) && ($urandom_range(0, 1) == 1));
    end

    // RD_LAT=5 instance: fill, single-block latency, wrap and random reads.
    sel = 1'b1;
    run_req(DRAM_REQ_WRITE, 32'h000, 32'd16, 32'h7700, 1'b1, 1'b0);
    run_req(DRAM_REQ_READ,  32'h028, 32'd1,  32'h0,    1'b1, 1'b0);
    run_req(DRAM_REQ_WRITE, 32'h070, 32'd3,  32'hE0,   1'b1, 1'b0);
    run_req(DRAM_REQ_READ,  32'h070, 32'd3,  32'h0,    1'b1, 1'b0);
    run_req(DRAM_REQ_READ,  32'h078, 32'd4,  32'h0,    1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      rq = ($urandom_range(0, 1) == 1) ? DRAM_REQ_READ : DRAM_REQ_WRITE;
      ra = 32'($urandom_range(0, 255));
      rn = 32'($urandom_range(1, 5));
      run_req(rq, ra, rn, $urandom, 1'b1, 1'b0);
    end
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
